// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-at-a-time imem requests and buffers
// returned words in a small FIFO that feeds the decoder; branch redirects flush everything.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc8,
  output logic        instr_valid,
  input  logic        dec_ready
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] Depth   = CntW'(FIFO_DEPTH);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     drop_addr_q, drop_addr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]     mem_instr_q [FIFO_DEPTH];
  logic [31:0]     mem_pc_q    [FIFO_DEPTH];

  logic        push, pop, empty;
  logic [31:0] target;
  logic        unused_target_lsbs;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign target             = {branch_target[31:2], 2'b00};
  assign unused_target_lsbs = ^branch_target[1:0];
  assign empty              = (count_q == '0);
  // Head is hidden during a redirect so a wrong-path word is never consumed.
  assign instr_valid        = !empty && !branch_valid;
  assign pop                = instr_valid && dec_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Storage is never read while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr_q[wr_ptr_q] <= imem_rdata;
      mem_pc_q[wr_ptr_q]    <= fetch_pc_q;
    end
  end

  // PC and FIFO bookkeeping
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    push        = 1'b0;
    if (branch_valid) begin
      fetch_pc_d = target;
      // Remember the stale address so the pending request stays stable until acked.
      if (state_q == StReq && !imem_ack) drop_addr_d = fetch_pc_q;
    end else if (state_q == StReq && imem_ack) begin
      push       = 1'b1;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (branch_valid) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (count_d < Depth) state_d = StReq;
      end
      StReq: begin
        if (branch_valid) begin
          state_d = imem_ack ? StReq : StDrop;
        end else if (imem_ack) begin
          state_d = (count_d < Depth) ? StReq : StIdle;
        end
      end
      StDrop: begin
        if (imem_ack) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fetch_pc_q;
    unique case (state_q)
      StIdle: imem_req = 1'b0;
      StReq:  imem_req = 1'b1;
      StDrop: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
      end
      default: imem_req = 1'b0;
    endcase
  end

  assign instr     = empty ? '0 : mem_instr_q[rd_ptr_q];
  assign instr_pc  = empty ? '0 : mem_pc_q[rd_ptr_q];
  assign instr_pc8 = empty ? '0 : mem_pc_q[rd_ptr_q] + 32'd8;

endmodule
